// File: rtl/audio_pkg.sv
`timescale 1ns / 1ps
// Shared constants and types for the codec DAC output path.
package audio_pkg;

  localparam int   AUDIO_DATA_W = 16;
  localparam logic LEFT_LRCK    = 1'b0;

  typedef enum logic {
    S_WAIT_LR,
    S_RUN
  } ser_state_e;

endpackage

// File: rtl/audio_dac_serializer_fifo.sv
`timescale 1ns / 1ps
// Small synchronous sample FIFO; push/pop are pre-qualified by the caller.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic                     i_pop,
  output logic signed [DATA_W-1:0] o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;

  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  assign o_rdata = mem[rd_ptr];
  assign o_full  = (o_count == CW'(DEPTH));
  assign o_empty = (o_count == '0);

endmodule

// File: rtl/audio_dac_serializer.sv
`timescale 1ns / 1ps
// I2S DAC serializer: buffers mono samples and shifts them MSB-first into both
// channel slots, slaved to the codec's BCLK/DACLRCK.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W   = AUDIO_DATA_W,
  parameter int DEPTH    = 4,
  parameter int SYNC_STG = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_mute,
  input  logic                     i_bclk,
  input  logic                     i_daclrck,
  output logic                     o_dacdat,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_IDLE = CNT_W'(DATA_W);

  logic [SYNC_STG-1:0]      bclk_sync_p0;
  logic [SYNC_STG-1:0]      lrck_sync_p0;
  logic                     bclk_p1;
  logic                     lrck_p1;
  logic                     bclk_s;
  logic                     lrck_s;
  logic                     bclk_fall;
  logic                     lr_edge;
  logic                     left_edge;
  logic                     shift_en;
  ser_state_e               state_q;
  ser_state_e               state_d;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop_ok;
  logic                     push_ok;
  logic                     ovf;
  logic signed [DATA_W-1:0] fifo_rdata;
  logic signed [DATA_W-1:0] load_word;
  logic signed [DATA_W-1:0] held_word_p2;
  logic signed [DATA_W-1:0] shreg_p2;
  logic [CNT_W-1:0]         bit_cnt_p2;

  // Stage p0/p1: synchronise codec clocks, keep previous value for edge detect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sync_p0 <= '0;
      lrck_sync_p0 <= '0;
      bclk_p1      <= 1'b0;
      lrck_p1      <= 1'b0;
    end else begin
      bclk_sync_p0 <= SYNC_STG'({bclk_sync_p0, i_bclk});
      lrck_sync_p0 <= SYNC_STG'({lrck_sync_p0, i_daclrck});
      bclk_p1      <= bclk_s;
      lrck_p1      <= lrck_s;
    end
  end

  assign bclk_s    = bclk_sync_p0[SYNC_STG-1];
  assign lrck_s    = lrck_sync_p0[SYNC_STG-1];
  assign bclk_fall = bclk_p1 & ~bclk_s;
  assign lr_edge   = lrck_s ^ lrck_p1;
  assign left_edge = lr_edge & (lrck_s == LEFT_LRCK);
  // An LR edge owns its coincident BCLK fall: that fall becomes the I2S delay bit.
  assign shift_en  = bclk_fall & ~lr_edge & (state_q == S_RUN);

  assign pop_ok    = left_edge & ~fifo_empty;
  assign push_ok   = i_valid & (~fifo_full | pop_ok);
  assign ovf       = i_valid & fifo_full & ~pop_ok;
  assign load_word = pop_ok ? fifo_rdata : held_word_p2;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_ok),
    .i_wdata (i_data),
    .i_pop   (pop_ok),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_WAIT_LR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_WAIT_LR && lr_edge) state_d = S_RUN;
  end

  // Stage p2: held word, shift register and serial output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      held_word_p2 <= '0;
      shreg_p2     <= '0;
      bit_cnt_p2   <= CNT_IDLE;
      o_dacdat     <= 1'b0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      o_overflow  <= ovf;
      o_underflow <= left_edge & fifo_empty;
      if (lr_edge) begin
        if (pop_ok) held_word_p2 <= fifo_rdata;
        shreg_p2   <= i_mute ? '0 : load_word;
        bit_cnt_p2 <= '0;
        o_dacdat   <= 1'b0;
      end else if (shift_en) begin
        if (bit_cnt_p2 < CNT_IDLE) begin
          o_dacdat   <= shreg_p2[DATA_W-1];
          shreg_p2   <= {shreg_p2[DATA_W-2:0], 1'b0};
          bit_cnt_p2 <= bit_cnt_p2 + 1'b1;
        end else begin
          o_dacdat   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
`timescale 1ns / 1ps
// Bench for audio_dac_serializer: a codec model drives BCLK = i_clk/8 and
// toggles LRCK every 32 BCLK, capturing each 32-bit slot on rising BCLK.
module tb_audio_dac_serializer;

  typedef struct packed {
    logic [15:0] word;
    logic        left;
    logic        pad;
  } slot_t;

  typedef struct packed {
    logic [15:0] word;
    logic        left;
  } exp_t;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_valid;
  logic signed [15:0] i_data;
  logic               i_mute;
  logic               i_bclk;
  logic               i_daclrck;
  logic               o_dacdat;
  logic [2:0]         o_fifo_count;
  logic               o_overflow;
  logic               o_underflow;

  slot_t obs_q[$];
  exp_t  exp_q[$];
  int    errors  = 0;
  int    checks  = 0;
  int    uf_cnt  = 0;
  int    ovf_cnt = 0;

  audio_dac_serializer #(
    .DATA_W   (16),
    .DEPTH    (4),
    .SYNC_STG (2)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_mute       (i_mute),
    .i_bclk       (i_bclk),
    .i_daclrck    (i_daclrck),
    .o_dacdat     (o_dacdat),
    .o_fifo_count (o_fifo_count),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  // Codec model: edges on i_clk negedges, slot capture on rising BCLK.
  initial begin : codec
    int          fall_cnt;
    int          rise_idx;
    logic [15:0] cap_word;
    logic        cap_pad;
    fall_cnt  = 0;
    rise_idx  = 0;
    cap_word  = '0;
    cap_pad   = 1'b0;
    i_bclk    = 1'b1;
    i_daclrck = 1'b1;
    forever begin
      repeat (4) @(negedge i_clk);
      i_bclk = 1'b0;
      fall_cnt++;
      if (fall_cnt == 32) begin
        fall_cnt  = 0;
        i_daclrck = ~i_daclrck;
        rise_idx  = 0;
        cap_word  = '0;
        cap_pad   = 1'b0;
      end
      repeat (4) @(negedge i_clk);
      i_bclk = 1'b1;
      if (rise_idx >= 1 && rise_idx <= 16) cap_word = {cap_word[14:0], o_dacdat};
      else if (rise_idx >= 17)             cap_pad  = cap_pad | o_dacdat;
      if (rise_idx == 31) obs_q.push_back('{cap_word, (i_daclrck == 1'b0), cap_pad});
      rise_idx++;
    end
  end

  always @(negedge i_clk) begin
    if (o_underflow === 1'b1) uf_cnt  <= uf_cnt + 1;
    if (o_overflow === 1'b1)  ovf_cnt <= ovf_cnt + 1;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (at posedge) until LRCK becomes val, then drops stale captured slots.
  task automatic wait_lr(input logic val);
    int n = 0;
    while (i_daclrck === val && n < 1000) begin @(posedge i_clk); n++; end
    while (i_daclrck !== val && n < 1000) begin @(posedge i_clk); n++; end
    chk("lr_wait_timeout", 32'(n < 1000), 32'd1);
    obs_q.delete();
  endtask

  task automatic send(input logic [15:0] d);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = d;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [15:0] w);
    exp_q.push_back('{w, 1'b1});
    exp_q.push_back('{w, 1'b0});
  endtask

  task automatic check_slot(input string tag);
    slot_t s;
    exp_t  e;
    int    n = 0;
    e = exp_q.pop_front();
    while (obs_q.size() == 0 && n < 1000) begin @(posedge i_clk); n++; end
    if (obs_q.size() == 0) s = '{16'hxxxx, 1'bx, 1'bx};
    else                   s = obs_q.pop_front();
    chk({tag, "_word"}, 32'(s.word), 32'(e.word));
    chk({tag, "_side"}, 32'(s.left), 32'(e.left));
    chk({tag, "_pad"},  32'(s.pad),  32'd0);
  endtask

  initial begin : stim
    int uf0;
    int ovf0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_mute  = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_dacdat", 32'(o_dacdat), 32'd0);
    chk("rst_count",  32'(o_fifo_count), 32'd0);
    chk("rst_ovf",    32'(o_overflow), 32'd0);
    chk("rst_uf",     32'(o_underflow), 32'd0);
    repeat (10) @(negedge i_clk);
    i_rst = 1'b0;

    // Basic frame: one sample on both slots
    wait_lr(1'b1);
    send(16'hA5C3);
    chk("a5c3_count_pre", 32'(o_fifo_count), 32'd1);
    expect_frame(16'hA5C3);
    wait_lr(1'b0);
    repeat (8) @(negedge i_clk);
    chk("a5c3_count_post", 32'(o_fifo_count), 32'd0);
    check_slot("a5c3_l");
    check_slot("a5c3_r");

    // Underflow re-send, then overflow with five strobes
    uf0 = uf_cnt;
    wait_lr(1'b0);
    repeat (8) @(negedge i_clk);
    chk("uf_first", 32'(uf_cnt - uf0), 32'd1);
    expect_frame(16'hA5C3);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1;
      case (k)
        0:       i_data = 16'h8001;
        1:       i_data = 16'h4C4C;
        2:       i_data = 16'h0F0F;
        3:       i_data = 16'h1234;
        default: i_data = 16'hDEAD;
      endcase
      @(negedge i_clk);
      chk($sformatf("ovf_pulse_%0d", k), 32'(o_overflow), 32'(k == 4));
    end
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("ovf_count_full", 32'(o_fifo_count), 32'd4);
    chk("ovf_pulse_off", 32'(o_overflow), 32'd0);
    expect_frame(16'h8001);
    expect_frame(16'h4C4C);
    expect_frame(16'h0F0F);
    expect_frame(16'h1234);
    expect_frame(16'h1234);
    for (int i = 0; i < 12; i++) check_slot($sformatf("ovf_slot%0d", i));
    chk("uf_second", 32'(uf_cnt - uf0), 32'd2);
    chk("ovf_drain", 32'(o_fifo_count), 32'd0);

    // Full FIFO with a strobe on the left-edge pop cycle
    wait_lr(1'b1);
    send(16'hC001);
    send(16'hC002);
    send(16'hC003);
    send(16'hC004);
    chk("full_count", 32'(o_fifo_count), 32'd4);
    ovf0 = ovf_cnt;
    wait_lr(1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = 16'h5A5A;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("pushpop_count", 32'(o_fifo_count), 32'd4);
    chk("pushpop_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
    expect_frame(16'hC001);
    expect_frame(16'hC002);
    expect_frame(16'hC003);
    expect_frame(16'hC004);
    expect_frame(16'h5A5A);
    for (int i = 0; i < 10; i++) check_slot($sformatf("pp_slot%0d", i));

    // Mute: sample still popped, zeros serialised
    wait_lr(1'b1);
    send(16'h7FFF);
    i_mute = 1'b1;
    chk("mute_count_pre", 32'(o_fifo_count), 32'd1);
    wait_lr(1'b0);
    repeat (8) @(negedge i_clk);
    chk("mute_count_post", 32'(o_fifo_count), 32'd0);
    expect_frame(16'h0000);
    check_slot("mute_l");
    check_slot("mute_r");
    i_mute = 1'b0;

    // Reset mid-shift
    wait_lr(1'b1);
    send(16'hFFFF);
    send(16'hFFFF);
    wait_lr(1'b0);
    repeat (40) @(negedge i_clk);
    chk("pre_rst_dacdat", 32'(o_dacdat), 32'd1);
    chk("pre_rst_count", 32'(o_fifo_count), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_dacdat", 32'(o_dacdat), 32'd0);
    chk("mid_rst_count", 32'(o_fifo_count), 32'd0);
    chk("mid_rst_ovf", 32'(o_overflow), 32'd0);
    chk("mid_rst_uf", 32'(o_underflow), 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    uf0 = uf_cnt;
    wait_lr(1'b1);
    exp_q.push_back('{16'h0000, 1'b0});
    exp_q.push_back('{16'h0000, 1'b1});
    check_slot("post_rst_r");
    check_slot("post_rst_l");
    chk("post_rst_uf", 32'(uf_cnt - uf0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
